// File: rtl/encode_requant_acc.sv
// encode_requant_acc: sums a group of signed products plus bias, then
// rounds half-up, shifts, saturates and presents one result per group.
module encode_requant_acc #(
   parameter int IN_W  = 60,
   parameter int CNT_W = 10,
   parameter int ACC_W = 70,
   parameter int OUT_W = 16
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    ce,
   input  logic [CNT_W-1:0]        cfg_len,
   input  logic [5:0]              cfg_shift,
   input  logic signed [IN_W-1:0]  cfg_bias,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_ACC = 2'd0,
      S_RND = 2'd1,
      S_OUT = 2'd2
   } state_t;

   localparam logic signed [ACC_W:0] MAXV =
      {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV =
      {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] MAXO =
      {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MINO =
      {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] ONE_CNT =
      {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ACC_W:0] ONE_W =
      {{ACC_W{1'b0}}, 1'b1};

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         r_len;
   logic [5:0]               r_shift;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_valid;
   logic signed [OUT_W-1:0]  r_data;
   logic                     r_sat;

   logic                     w_first;
   logic [CNT_W-1:0]         w_len;
   logic [CNT_W-1:0]         w_cnt_nx;
   logic                     w_last;
   logic signed [ACC_W-1:0]  w_in_ext;
   logic signed [ACC_W-1:0]  w_bias_ext;
   logic signed [ACC_W-1:0]  w_acc_nx;
   logic [ACC_W:0]           w_rnd_term;
   logic signed [ACC_W:0]    w_sum;
   logic signed [ACC_W:0]    w_r;
   logic signed [OUT_W-1:0]  w_q;
   logic                     w_q_sat;

   assign in_ready  = ce & (r_state == S_ACC);
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sat   = r_sat;
   assign busy      = (r_cnt != '0) | (r_state != S_ACC);

   // Beat bookkeeping, accumulation and the round/shift/saturate datapath
   always_comb begin
      w_first    = (r_cnt == '0);
      w_len      = r_len;
      if (w_first) begin
         w_len = (cfg_len == '0) ? ONE_CNT : cfg_len;
      end
      w_cnt_nx   = r_cnt + ONE_CNT;
      w_last     = (w_cnt_nx == w_len);
      w_in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
      w_bias_ext = {{(ACC_W-IN_W){cfg_bias[IN_W-1]}}, cfg_bias};
      w_acc_nx   = w_first ? (w_bias_ext + w_in_ext)
                           : (r_acc + w_in_ext);
      w_rnd_term = '0;
      if (r_shift != 6'd0) begin
         w_rnd_term = ONE_W << (r_shift - 6'd1);
      end
      w_sum      = {r_acc[ACC_W-1], r_acc} + $signed(w_rnd_term);
      w_r        = w_sum >>> r_shift;
      w_q        = w_r[OUT_W-1:0];
      w_q_sat    = 1'b0;
      if (w_r > MAXV) begin
         w_q     = MAXO;
         w_q_sat = 1'b1;
      end else if (w_r < MINV) begin
         w_q     = MINO;
         w_q_sat = 1'b1;
      end
   end

   // Group FSM with registered result outputs; ce=0 freezes everything
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= S_ACC;
         r_cnt   <= '0;
         r_len   <= '0;
         r_shift <= '0;
         r_acc   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sat   <= 1'b0;
      end else if (ce) begin
         unique case (r_state)
            S_ACC: begin
               if (in_valid) begin
                  r_acc <= w_acc_nx;
                  if (w_first) begin
                     r_len   <= w_len;
                     r_shift <= cfg_shift;
                  end
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= S_RND;
                  end else begin
                     r_cnt <= w_cnt_nx;
                  end
               end
            end
            S_RND: begin
               r_data  <= w_q;
               r_sat   <= w_q_sat;
               r_valid <= 1'b1;
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_ACC;
               end
            end
            default: begin
               r_state <= S_ACC;
            end
         endcase
      end
   end

endmodule
